pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline register for the RV32I core. It is the next generation of the
//  fixed IF/ID latch: generic payload width, valid/ready handshake, flush-to-bubble, hazard hold
//  and a stall-cycle counter. Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//  DATA_W        96                 payload width (default = instruction + PC + PC+4)
//  BUBBLE_VALUE  {DATA_W{1'b0}}     out_data while the stage is empty (after reset or flush)
//  CNT_W         16                 stall_cycles counter width, saturating
// PORTS
//  clock         in   1        single clock; all state updates on posedge
//  sync_reset    in   1        synchronous, active-high reset
//  flush         in   1        sync, drop all held entries (branch/jump redirect)
//  hold          in   1        hazard-unit freeze: no push, no pop this cycle
//  in_valid      in   1        upstream has data
//  in_ready      out  1        stage accepts data this cycle
//  in_data       in   DATA_W   upstream payload
//  out_valid     out  1        stage presents data (masked by hold)
//  out_ready     in   1        downstream accepts
//  out_data      out  DATA_W   head payload, BUBBLE_VALUE when empty
//  occupancy     out  2        entries held (0..1 base, 0..2 with skid)
//  stall_cycles  out  CNT_W    cycles with head valid, !out_ready, !hold
// BEHAVIOUR
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Latency in->out = 1 cycle.
//  - Priority per cycle: sync_reset > flush > hold > normal push/pop.
//  - Reset: out_valid=0, out_data=BUBBLE_VALUE, occupancy=0, stall_cycles=0, in_ready=1 next cycle.
//  - Flush: all entries invalid, out_data=BUBBLE_VALUE next cycle; a push in the flush cycle is
//    dropped; stall_cycles retained. Flush with hold=1 still flushes.
//  - Hold=1: in_ready=0, out_valid=0 (head retained, unchanged); the counter does not count.
//  - Ordering strictly FIFO; no entry is ever lost or duplicated under any ready/valid pattern.
//  - Empty + push + no pop: head loads in_data. Head valid + pop + push: head loads in_data
//    (full throughput, no bubble). Pop with no push: stage empties, out_data=BUBBLE_VALUE.
//  - stall_cycles increments when head valid & !out_ready & !hold & !flush; saturates at
//    2**CNT_W-1, never wraps; cleared only by sync_reset.
//  - in_data/out_data not X-propagated: held registers update only on push.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined: two-entry (head + skid) buffer; in_ready = !skid_valid, fully
//    registered (no comb path out_ready->in_ready). A push while head stalled goes to skid;
//    on pop, skid moves to head. Stall with both full -> in_ready=0 next cycle.
//  Undefined: single entry; in_ready = !head_valid | out_ready (combinational); occupancy<=1.
//  Both builds are identical at the transaction level; only in_ready timing differs.
// STRUCTURE
//  - pipe_pkg: IF/ID payload struct typedef (instr, pc, pc_plus_4), DATA_W_IFID localparam,
//    RV32I NOP constant (32'h0000_0013) for use as BUBBLE_VALUE in IF/ID instances.
//  - One sub-module, pipe_skid_buf (head/skid regs + ready logic), instantiated only under
//    PIPE_STAGE_SKID_EN; the counter and hold/flush masking live in the top.
// TESTING
//  1 Reset: sync_reset=1 one cycle mid-traffic -> out_valid=0, out_data=BUBBLE_VALUE,
//    occupancy=0, stall_cycles=0, in_ready=1.
//  2 Stream: in_valid=1 with data 1,2,3,4, out_ready=1 -> out_data 1,2,3,4 one cycle later, no gaps.
//  3 Backpressure (SKID_EN): push A,B,C with out_ready=0 for 2 cycles -> head=A, skid=B,
//    in_ready=0, C waits; release -> A,B,C in order; stall_cycles=2.
//  4 Flush with occupancy=2 and in_valid=1 (D) -> next cycle out_valid=0, occupancy=0,
//    in_ready=1, D never appears at output.
//  5 Hold=1 with head=E and out_ready=1 for 3 cycles -> out_valid=0, in_ready=0, E retained,
//    stall_cycles unchanged; hold=0 -> E popped next cycle.
//  6 CNT_W=4, head valid, out_ready=0 for 20 cycles -> stall_cycles=15 (saturated, no wrap).

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the RV32I pipeline registers.
//               Holds the IF/ID payload layout, its width, and the RV32I NOP
//               encoding that IF/ID stages present as their bubble value.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // IF/ID payload: fetched instruction plus the PC and PC+4 that go with it.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
    } ifid_payload_t;

    localparam int DATA_W_IFID = $bits(ifid_payload_t);

    // addi x0, x0, 0
    localparam logic [31:0] c_RV32I_NOP = 32'h0000_0013;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Two-entry head/skid storage for the elastic pipeline stage.
//               The head is what downstream sees; the skid catches one extra
//               push while the head is stalled, so upstream ready can be taken
//               straight from a register.
// Ports       : clock, sync_reset  - clock and synchronous active-high reset
//               i_flush            - invalidate both entries
//               i_push / i_pop     - qualified handshakes from the top level
//               i_data             - payload to store on push
//               o_head_valid/data  - head entry
//               o_skid_valid       - skid entry occupied (drives in_ready)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int DATA_W = 96
) (
    input  logic              clock,
    input  logic              sync_reset,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_head_valid,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_skid_valid
);

    logic              r_head_valid;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_head_data;
    logic [DATA_W-1:0] r_skid_data;

    // Upstream only sees ready when the skid is empty, so a push never
    // coincides with an occupied skid.
    always_ff @(posedge clock) begin
        if (sync_reset) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (i_flush) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            if (i_pop) begin
                r_head_data  <= r_skid_data;
                r_skid_valid <= 1'b0;
            end
        end else if (r_head_valid) begin
            if (i_push && i_pop) begin
                r_head_data <= i_data;
            end else if (i_push) begin
                r_skid_data  <= i_data;
                r_skid_valid <= 1'b1;
            end else if (i_pop) begin
                r_head_valid <= 1'b0;
            end
        end else if (i_push) begin
            r_head_valid <= 1'b1;
            r_head_data  <= i_data;
        end
    end

    assign o_head_valid = r_head_valid;
    assign o_head_data  = r_head_data;
    assign o_skid_valid = r_skid_valid;

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Elastic pipeline register with valid/ready handshake,
//               flush-to-bubble, hazard hold and a saturating stall counter.
//               Build option PIPE_STAGE_SKID_EN selects a two-entry head/skid
//               buffer with registered in_ready; otherwise a single entry with
//               combinational in_ready.
// Ports       : clock, sync_reset     - clock, synchronous active-high reset
//               flush                 - drop all held entries
//               hold                  - freeze: no push, no pop
//               in_valid/in_ready/in_data    - upstream handshake
//               out_valid/out_ready/out_data - downstream handshake
//               occupancy             - entries currently held
//               stall_cycles          - saturating count of stalled cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W       = DATA_W_IFID,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = {DATA_W{1'b0}},
    parameter int                CNT_W        = 16
) (
    input  logic              clock,
    input  logic              sync_reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic              w_head_valid;
    logic [DATA_W-1:0] w_head_data;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  r_stall_cycles;

    // Hold hides the head from downstream without disturbing it.
    assign out_valid = w_head_valid & ~hold;
    assign w_pop     = out_valid & out_ready;
    assign w_push    = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic w_skid_valid;

    pipe_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid_buf (
        .clock        (clock),
        .sync_reset   (sync_reset),
        .i_flush      (flush),
        .i_push       (w_push),
        .i_pop        (w_pop),
        .i_data       (in_data),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data),
        .o_skid_valid (w_skid_valid)
    );

    // Depends only on state and hold; no path from out_ready.
    assign in_ready  = ~w_skid_valid & ~hold;
    assign occupancy = {1'b0, w_head_valid} + {1'b0, w_skid_valid};
`else
    logic              r_head_valid;
    logic [DATA_W-1:0] r_head_data;

    always_ff @(posedge clock) begin
        if (sync_reset) begin
            r_head_valid <= 1'b0;
        end else if (flush) begin
            r_head_valid <= 1'b0;
        end else if (w_push) begin
            r_head_valid <= 1'b1;
            r_head_data  <= in_data;
        end else if (w_pop) begin
            r_head_valid <= 1'b0;
        end
    end

    assign w_head_valid = r_head_valid;
    assign w_head_data  = r_head_data;
    assign in_ready     = ~hold & (~r_head_valid | out_ready);
    assign occupancy    = {1'b0, r_head_valid};
`endif

    // Data registers keep stale contents when empty; the bubble is muxed here.
    assign out_data = w_head_valid ? w_head_data : BUBBLE_VALUE;

    // Survives flush; only reset clears it.
    always_ff @(posedge clock) begin
        if (sync_reset) begin
            r_stall_cycles <= '0;
        end else if (w_head_valid && !out_ready && !hold && !flush
                     && (r_stall_cycles != c_CNT_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule : pipe_stage_elastic
`default_nettype wire
